multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Registered multi-cycle control unit; parametrised successor of the combinational opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath strobes plus PC/IR enables.
//  Handles variable memory latency, HALT/restart, and flags illegal opcodes.
// PARAMETERS
//  OPW     3  opcode width (>=3); opcodes >= 8 are illegal
//  ALUOPW  3  ALUOp width
//  MEM_LAT 2  cycles spent in MEM for load/store (>=1)
// PORTS
//  Clk        in   1       clock, rising edge
//  Reset_n    in   1       asynchronous, active-low reset
//  Start      in   1       leave IDLE/HALT and begin fetching
//  instr      in   OPW     opcode field; sampled in DECODE only
//  Stall      in   1       freeze request (honoured only with CTRL_STALL_EN)
//  RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite  out 1  datapath strobes
//  ALUOp      out  ALUOPW  ALU operation select
//  PCWrite    out  1       advance/update PC this cycle
//  IRWrite    out  1       load instruction register this cycle
//  Busy       out  1       1 in any state except IDLE/HALT
//  Done       out  1       1 while in HALT
//  IllegalOp  out  1       one-cycle pulse in EXEC for illegal opcode
// BEHAVIOUR
//  - All outputs registered. On Reset_n=0: state=IDLE, all 1-bit outputs 0, ALUOp='b111;
//    applies immediately (mid-MEM MemWrite drops asynchronously), no partial commit.
//  - Decode map (latched in DECODE): 000 load: ALUSrc,MemtoReg; 001 store: ALUSrc,MemWrite;
//    010 branch: Branch; 011/110 reg ALU op, ALUOp='b111; 100 rotate: ALUSrc, ALUOp='b100;
//    101 AND: ALUSrc, ALUOp='b101; 111 halt. RegDst always 0. Default ALUOp='b111.
//  - IDLE: Start=1 -> FETCH. FETCH: IRWrite=1 (1 cycle) -> DECODE -> EXEC.
//  - EXEC ALU ops: RegWrite=1, PCWrite=1 -> FETCH (3 cycles/instr).
//  - EXEC branch: Branch=1, PCWrite=1, RegWrite=0 -> FETCH.
//  - EXEC load/store: ALUSrc=1 -> MEM; latency counter loads MEM_LAT-1, counts down to 0.
//    Store: MemWrite=1 on first MEM cycle only; exit MEM -> FETCH with PCWrite=1.
//    Load: exit MEM -> WB: RegWrite=1, MemtoReg=1, PCWrite=1 -> FETCH (3+MEM_LAT+1 cycles).
//  - Halt: EXEC -> HALT, no PCWrite. HALT: Done=1; Start=1 -> FETCH, Done clears next cycle.
//  - Illegal opcode: IllegalOp=1, PCWrite=1, no RegWrite/MemWrite -> FETCH (treated as NOP).
//  - Start ignored while Busy. Strobes other than ALUOp/ALUSrc/MemtoReg are 0 outside their state.
//  - Counter width $clog2(MEM_LAT+1); MEM_LAT=1 -> exactly one MEM cycle.
// CONFIGURATION
//  CTRL_STALL_EN defined: Stall=1 holds state and counter; PCWrite/IRWrite/RegWrite/MemWrite
//    forced 0 that cycle; store MemWrite still issued exactly once after Stall releases.
//  CTRL_STALL_EN undefined: Stall port present but ignored; FSM never freezes.
// STRUCTURE
//  ctrl_pkg: state enum (IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT), opcode localparams,
//    ALUOp constants ('b111 pass, 'b100 rotate, 'b101 and), ctrl_word_t struct of strobes.
//  Sub-module op_decode: combinational instr -> ctrl_word_t + illegal flag; FSM in top latches it.
// TESTING
//  1 Reset_n low mid-MEM of store: MemWrite=0 same cycle, state IDLE, ALUOp='b111, Busy=0.
//  2 Start, instr=011: IRWrite@c1, RegWrite+PCWrite@c3, next IRWrite@c4.
//  3 MEM_LAT=2, instr=000: 2 MEM cycles, WB RegWrite=MemtoReg=1 at c6, PCWrite same cycle.
//  4 instr=001, MEM_LAT=3: MemWrite high exactly 1 cycle, RegWrite never 1, PCWrite on MEM exit.
//  5 instr=111: Done=1, Busy=0, holds; Start pulse -> IRWrite next cycle, Done=0.
//  6 OPW=4, instr=4'b1010: IllegalOp 1-cycle pulse, PCWrite=1, no RegWrite/MemWrite.
//  7 CTRL_STALL_EN, Stall=1 for 4 cycles during MEM: counter frozen, single MemWrite, +4 latency.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcodes, ALUOp codes
// and the control word produced by the opcode decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_STORE  = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_ALU    = 3'b011;
    localparam logic [2:0] OP_ROT    = 3'b100;
    localparam logic [2:0] OP_AND    = 3'b101;
    localparam logic [2:0] OP_ALU2   = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [2:0] ALUOP_PASS = 3'b111;
    localparam logic [2:0] ALUOP_ROT  = 3'b100;
    localparam logic [2:0] ALUOP_AND  = 3'b101;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       is_load;
        logic       is_store;
        logic       is_halt;
        logic [2:0] alu_op;
    } ctrl_word_t;

    // Illegal opcodes decode to this word, so they retire as a plain PC advance.
    localparam ctrl_word_t CW_NOP = '{
        reg_dst:    1'b0,
        branch:     1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        reg_write:  1'b0,
        is_load:    1'b0,
        is_store:   1'b0,
        is_halt:    1'b0,
        alu_op:     ALUOP_PASS
    };

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: opcode field -> control word plus illegal flag.
// Any set bit above bit 2 marks the opcode illegal.
module op_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] instr,
    output ctrl_word_t     cw,
    output logic           illegal
);

    logic upper_nz_s;

    if (OPW > 3) begin : g_wide
        assign upper_nz_s = |instr[OPW-1:3];
    end else begin : g_narrow
        assign upper_nz_s = 1'b0;
    end

    // Opcode to control-word map.
    always_comb begin
        cw      = CW_NOP;
        illegal = 1'b0;
        if (upper_nz_s) begin
            illegal = 1'b1;
        end else begin
            case (instr[2:0])
                OP_LOAD: begin
                    cw.alu_src    = 1'b1;
                    cw.mem_to_reg = 1'b1;
                    cw.is_load    = 1'b1;
                end
                OP_STORE: begin
                    cw.alu_src   = 1'b1;
                    cw.mem_write = 1'b1;
                    cw.is_store  = 1'b1;
                end
                OP_BRANCH: cw.branch = 1'b1;
                OP_ALU, OP_ALU2: cw.reg_write = 1'b1;
                OP_ROT: begin
                    cw.alu_src   = 1'b1;
                    cw.reg_write = 1'b1;
                    cw.alu_op    = ALUOP_ROT;
                end
                OP_AND: begin
                    cw.alu_src   = 1'b1;
                    cw.reg_write = 1'b1;
                    cw.alu_op    = ALUOP_AND;
                end
                OP_HALT: cw.is_halt = 1'b1;
                default: cw = CW_NOP;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Registered multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB, HALT/restart).
// Optional freeze input enabled by defining CTRL_STALL_EN.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int ALUOPW  = 3,
    parameter int MEM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [OPW-1:0]    instr,
    input  logic              Stall,
    output logic              RegDst,
    output logic              Branch,
    output logic              MemtoReg,
    output logic              MemWrite,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic              Busy,
    output logic              Done,
    output logic              IllegalOp
);

    localparam int              CNTW     = $clog2(MEM_LAT + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MEM_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(32'd1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    ctrl_word_t        cw_q, cw_d;
    ctrl_word_t        dec_cw_s;
    logic              dec_illegal_s;
    logic              stall_s;

    logic              reg_dst_q, reg_dst_d;
    logic              branch_q, branch_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic              alu_src_q, alu_src_d;
    logic              reg_write_q, reg_write_d;
    logic [ALUOPW-1:0] alu_op_q, alu_op_d;
    logic              pc_write_q, pc_write_d;
    logic              ir_write_q, ir_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              illegal_op_q, illegal_op_d;

`ifdef CTRL_STALL_EN
    assign stall_s = Stall;
`else
    logic unused_stall_s;
    assign unused_stall_s = Stall;
    assign stall_s        = 1'b0;
`endif

    op_decode #(.OPW(OPW)) u_op_decode (
        .instr   (instr),
        .cw      (dec_cw_s),
        .illegal (dec_illegal_s)
    );

    // Next state, latency counter and latched control word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        if (stall_s) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            cw_d    = cw_q;
        end else begin
            case (state_q)
                IDLE:   state_d = Start ? FETCH : IDLE;
                FETCH:  state_d = DECODE;
                DECODE: begin
                    state_d = EXEC;
                    cw_d    = dec_cw_s;
                end
                EXEC: begin
                    if (cw_q.is_halt) begin
                        state_d = HALT;
                    end else if (cw_q.is_load || cw_q.is_store) begin
                        state_d = MEM;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = FETCH;
                    end
                end
                MEM: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = cw_q.is_load ? WB : FETCH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                WB:     state_d = FETCH;
                HALT:   state_d = Start ? FETCH : HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs for the state being entered; they become visible with it after the edge.
    always_comb begin
        reg_dst_d    = 1'b0;
        branch_d     = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_op_d     = ALUOPW'(ALUOP_PASS);
        pc_write_d   = 1'b0;
        ir_write_d   = 1'b0;
        illegal_op_d = 1'b0;
        busy_d       = (state_d != IDLE) && (state_d != HALT);
        done_d       = (state_d == HALT);
        case (state_d)
            FETCH: ir_write_d = !stall_s;
            EXEC: begin
                reg_dst_d    = cw_d.reg_dst;
                branch_d     = cw_d.branch;
                mem_to_reg_d = cw_d.mem_to_reg;
                alu_src_d    = cw_d.alu_src;
                alu_op_d     = ALUOPW'(cw_d.alu_op);
                reg_write_d  = cw_d.reg_write && !stall_s;
                pc_write_d   = !stall_s && !cw_d.is_halt && !cw_d.is_load && !cw_d.is_store;
                illegal_op_d = !stall_s && dec_illegal_s;
            end
            MEM: begin
                // MemWrite only on the EXEC->MEM transition, so a stalled MEM never repeats it.
                mem_to_reg_d = cw_d.mem_to_reg;
                alu_src_d    = cw_d.alu_src;
                alu_op_d     = ALUOPW'(cw_d.alu_op);
                mem_write_d  = !stall_s && cw_d.mem_write && (state_q == EXEC);
                pc_write_d   = !stall_s && cw_d.is_store && (cnt_d == CNT_ZERO);
            end
            WB: begin
                mem_to_reg_d = 1'b1;
                alu_src_d    = cw_d.alu_src;
                alu_op_d     = ALUOPW'(cw_d.alu_op);
                reg_write_d  = !stall_s;
                pc_write_d   = !stall_s;
            end
            default: begin
                ir_write_d = 1'b0;
            end
        endcase
    end

    // State, counter, control word and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            cw_q         <= CW_NOP;
            reg_dst_q    <= 1'b0;
            branch_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_op_q     <= ALUOPW'(ALUOP_PASS);
            pc_write_q   <= 1'b0;
            ir_write_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cw_q         <= cw_d;
            reg_dst_q    <= reg_dst_d;
            branch_q     <= branch_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            alu_op_q     <= alu_op_d;
            pc_write_q   <= pc_write_d;
            ir_write_q   <= ir_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign RegDst    = reg_dst_q;
    assign Branch    = branch_q;
    assign MemtoReg  = mem_to_reg_q;
    assign MemWrite  = mem_write_q;
    assign ALUSrc    = alu_src_q;
    assign RegWrite  = reg_write_q;
    assign ALUOp     = alu_op_q;
    assign PCWrite   = pc_write_q;
    assign IRWrite   = ir_write_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign IllegalOp = illegal_op_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors are queued
// when an instruction is launched and compared as the DUT steps through it.
module tb_multicycle_control;

    localparam int OPW     = 4;
    localparam int ALUOPW  = 3;
    localparam int MEM_LAT = 3;
`ifdef CTRL_STALL_EN
    localparam int NST = 4;
`else
    localparam int NST = 0;
`endif

    localparam logic [OPW-1:0] I_LOAD  = 4'b0000;
    localparam logic [OPW-1:0] I_STORE = 4'b0001;
    localparam logic [OPW-1:0] I_BR    = 4'b0010;
    localparam logic [OPW-1:0] I_HALT  = 4'b0111;

    // Strobe field: {IR, PC, RW, MW, BR, IL, BUSY, DONE, RegDst}
    localparam logic [8:0] S_IR   = 9'b1_0000_0000;
    localparam logic [8:0] S_PC   = 9'b0_1000_0000;
    localparam logic [8:0] S_RW   = 9'b0_0100_0000;
    localparam logic [8:0] S_MW   = 9'b0_0010_0000;
    localparam logic [8:0] S_BR   = 9'b0_0001_0000;
    localparam logic [8:0] S_IL   = 9'b0_0000_1000;
    localparam logic [8:0] S_BUSY = 9'b0_0000_0100;
    localparam logic [8:0] S_DONE = 9'b0_0000_0010;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Start = 1'b0;
    logic              Stall = 1'b0;
    logic [OPW-1:0]    instr = 4'b0000;
    logic              RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [ALUOPW-1:0] ALUOp;
    logic              PCWrite, IRWrite, Busy, Done, IllegalOp;
    logic [13:0]       obs_s;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] q_exp[$];
    logic [13:0] q_msk[$];

    multicycle_control #(.OPW(OPW), .ALUOPW(ALUOPW), .MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .instr(instr), .Stall(Stall),
        .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .Busy(Busy), .Done(Done), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    assign obs_s = {IRWrite, PCWrite, RegWrite, MemWrite, Branch, IllegalOp, Busy, Done,
                    RegDst, ALUSrc, MemtoReg, ALUOp};

    // dp = {ALUSrc, MemtoReg, ALUOp}; dm selects which of those bits are checked.
    function automatic void exp_cyc(input logic [8:0] s, input logic [4:0] dp, input logic [4:0] dm);
        q_exp.push_back({s, dp});
        q_msk.push_back({9'h1FF, dm});
    endfunction

    function automatic void push_fetch_decode();
        exp_cyc(S_IR | S_BUSY, 5'b00000, 5'b00000);
        exp_cyc(S_BUSY, 5'b00000, 5'b00000);
    endfunction

    function automatic void push_halt_tail();
        push_fetch_decode();
        exp_cyc(S_BUSY, 5'b00000, 5'b00000);
        exp_cyc(S_DONE, 5'b00000, 5'b00000);
        exp_cyc(S_DONE, 5'b00000, 5'b00000);
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++;
        if (obs_s !== {9'b0, 5'b00111}) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", obs_s, {9'b0, 5'b00111});
        end
        Reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (obs_s[13:5] !== 9'b0) begin
                n_err++;
                $display("FAIL idle_hold: got %b want %b", obs_s[13:5], 9'b0);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [OPW-1:0] ops[4];
        logic [4:0]     dps[4];
        logic [13:0]    e, m;
        ops = '{4'b0011, 4'b0110, 4'b0100, 4'b0101};
        dps = '{5'b00111, 5'b00111, 5'b10100, 5'b10101};
        for (int k = 0; k < 4; k++) begin
            push_fetch_decode();
            exp_cyc(S_PC | S_RW | S_BUSY, dps[k], 5'b11111);
            push_halt_tail();
            instr = ops[k];
            Start = 1'b1;
            for (int c = 1; q_exp.size() > 0; c++) begin
                @(posedge Clk); #1;
                Start = 1'b0;
                if (c == 3) instr = I_HALT;
                e = q_exp.pop_front();
                m = q_msk.pop_front();
                n_cmp++;
                if ((obs_s & m) !== (e & m)) begin
                    n_err++;
                    $display("FAIL alu op=%b c%0d: got %b want %b mask %b", ops[k], c, obs_s, e, m);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [13:0] e, m;
        push_fetch_decode();
        exp_cyc(S_BR | S_PC | S_BUSY, 5'b00000, 5'b00000);
        push_halt_tail();
        instr = I_BR;
        Start = 1'b1;
        for (int c = 1; q_exp.size() > 0; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (c == 3) instr = I_HALT;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            n_cmp++;
            if ((obs_s & m) !== (e & m)) begin
                n_err++;
                $display("FAIL branch c%0d: got %b want %b mask %b", c, obs_s, e, m);
            end
        end
    endtask

    task automatic test_load();
        logic [13:0] e, m;
        push_fetch_decode();
        exp_cyc(S_BUSY, 5'b10000, 5'b10000);
        for (int j = 0; j < MEM_LAT; j++) exp_cyc(S_BUSY, 5'b00000, 5'b00000);
        exp_cyc(S_RW | S_PC | S_BUSY, 5'b01000, 5'b01000);
        push_halt_tail();
        instr = I_LOAD;
        Start = 1'b1;
        for (int c = 1; q_exp.size() > 0; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (c == 3) instr = I_HALT;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            n_cmp++;
            if ((obs_s & m) !== (e & m)) begin
                n_err++;
                $display("FAIL load c%0d: got %b want %b mask %b", c, obs_s, e, m);
            end
        end
    endtask

    // Store; with the stall feature built in, Stall freezes the second MEM cycle for NST cycles.
    task automatic test_store(input bit with_stall);
        logic [13:0] e, m;
        push_fetch_decode();
        exp_cyc(S_BUSY, 5'b10000, 5'b10000);
        exp_cyc(S_MW | S_BUSY, 5'b00000, 5'b00000);
        for (int j = 0; j < MEM_LAT - 2 + (with_stall ? NST : 0); j++)
            exp_cyc(S_BUSY, 5'b00000, 5'b00000);
        exp_cyc(S_PC | S_BUSY, 5'b00000, 5'b00000);
        push_halt_tail();
        instr = I_STORE;
        Start = 1'b1;
        for (int c = 1; q_exp.size() > 0; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (c == 3) instr = I_HALT;
            if (with_stall && c == 5) Stall = 1'b1;
            if (c == 9) Stall = 1'b0;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            n_cmp++;
            if ((obs_s & m) !== (e & m)) begin
                n_err++;
                $display("FAIL store stall=%0d c%0d: got %b want %b mask %b", with_stall, c, obs_s, e, m);
            end
        end
    endtask

    task automatic test_halt();
        logic [13:0] e, m;
        push_halt_tail();
        exp_cyc(S_DONE, 5'b00000, 5'b00000);
        instr = I_HALT;
        Start = 1'b1;
        for (int c = 1; q_exp.size() > 0; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            n_cmp++;
            if ((obs_s & m) !== (e & m)) begin
                n_err++;
                $display("FAIL halt c%0d: got %b want %b mask %b", c, obs_s, e, m);
            end
        end
    endtask

    task automatic test_illegal();
        logic [OPW-1:0] ops[2];
        logic [13:0]    e, m;
        ops = '{4'b1010, 4'b1111};
        for (int k = 0; k < 2; k++) begin
            push_fetch_decode();
            exp_cyc(S_IL | S_PC | S_BUSY, 5'b00000, 5'b00000);
            push_halt_tail();
            instr = ops[k];
            Start = 1'b1;
            for (int c = 1; q_exp.size() > 0; c++) begin
                @(posedge Clk); #1;
                Start = 1'b0;
                if (c == 3) instr = I_HALT;
                e = q_exp.pop_front();
                m = q_msk.pop_front();
                n_cmp++;
                if ((obs_s & m) !== (e & m)) begin
                    n_err++;
                    $display("FAIL illegal op=%b c%0d: got %b want %b mask %b", ops[k], c, obs_s, e, m);
                end
            end
        end
    endtask

    // Two ALU ops back to back with Start held high while busy (must be ignored).
    task automatic test_back_to_back();
        logic [13:0] e, m;
        for (int k = 0; k < 2; k++) begin
            push_fetch_decode();
            exp_cyc(S_PC | S_RW | S_BUSY, 5'b00111, 5'b11111);
        end
        push_halt_tail();
        instr = 4'b0011;
        Start = 1'b1;
        for (int c = 1; q_exp.size() > 0; c++) begin
            @(posedge Clk); #1;
            Start = (c < 3);
            if (c == 6) instr = I_HALT;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            n_cmp++;
            if ((obs_s & m) !== (e & m)) begin
                n_err++;
                $display("FAIL b2b c%0d: got %b want %b mask %b", c, obs_s, e, m);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        instr = I_STORE;
        Start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        n_cmp++;
        if (MemWrite !== 1'b1) begin
            n_err++;
            $display("FAIL mid_mem_mw: got %b want 1", MemWrite);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_s !== {9'b0, 5'b00111}) begin
            n_err++;
            $display("FAIL mid_mem_reset: got %b want %b", obs_s, {9'b0, 5'b00111});
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            n_cmp++;
            if (obs_s[13:5] !== 9'b0) begin
                n_err++;
                $display("FAIL post_reset_idle: got %b want %b", obs_s[13:5], 9'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_load();
        test_store(1'b0);
        test_halt();
        test_illegal();
        test_back_to_back();
        test_store(1'b1);
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
